// File: rtl/layer_sequencer_pkg.sv
// Shared types and helpers for the layer sequencer: strobe arbitration codes,
// geometry derivation and the minimum-width clog2 used for index ports.
package layer_pkg;

    typedef enum logic [2:0] {
        STB_NONE  = 3'd0,
        STB_CLOAD = 3'd1,
        STB_COUT  = 3'd2,
        STB_CONV  = 3'd3,
        STB_TREE  = 3'd4,
        STB_POOL  = 3'd5
    } stb_e;

    // An index port is never narrower than one bit, even for a single entry.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ow_of(input int img_w, input int k);
        return img_w - k + 1;
    endfunction

    function automatic int pw_of(input int ow);
        return ow / 2;
    endfunction

    function automatic stb_e stb_pick(input logic c_load, input logic cout,
                                      input logic conv, input logic tree,
                                      input logic pool);
        if (c_load)    return STB_CLOAD;
        else if (cout) return STB_COUT;
        else if (conv) return STB_CONV;
        else if (tree) return STB_TREE;
        else if (pool) return STB_POOL;
        else           return STB_NONE;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Layer control handshake: the controller drives phase strobes, the sequencer
// answers with indices, coordinates and completion status.
interface layer_sequencer_if #(
    parameter int IC    = 1,
    parameter int OC    = 1,
    parameter int IMG_W = 28,
    parameter int K     = 3
) ();
    localparam int OW  = layer_pkg::ow_of(IMG_W, K);
    localparam int PW  = layer_pkg::pw_of(OW);
    localparam int ICW = layer_pkg::clog2_min1(IC);
    localparam int OCW = layer_pkg::clog2_min1(OC);
    localparam int WW  = layer_pkg::clog2_min1(OW);
    localparam int PWW = layer_pkg::clog2_min1(PW);

    logic           c_load;
    logic           conv;
    logic           tree;
    logic           cout;
    logic           pool;
    logic           conv_done;
    logic           cout_done;
    logic           pool_done;
    logic [ICW-1:0] ic_idx;
    logic [OCW-1:0] oc_idx;
    logic           win_valid;
    logic [WW-1:0]  win_row;
    logic [WW-1:0]  win_col;
    logic           acc_clr;
    logic           tree_en;
    logic           pool_valid;
    logic [PWW-1:0] pool_row;
    logic [PWW-1:0] pool_col;
    logic           proto_err;

    modport master (
        output c_load, conv, tree, cout, pool,
        input  conv_done, cout_done, pool_done, ic_idx, oc_idx, win_valid,
               win_row, win_col, acc_clr, tree_en, pool_valid, pool_row,
               pool_col, proto_err
    );

    modport slave (
        input  c_load, conv, tree, cout, pool,
        output conv_done, cout_done, pool_done, ic_idx, oc_idx, win_valid,
               win_row, win_col, acc_clr, tree_en, pool_valid, pool_row,
               pool_col, proto_err
    );
endinterface

// File: rtl/layer_sequencer_xy_counter.sv
// Square (row, col) position counter, column innermost. At the last position
// it either wraps to the origin or holds there until cleared.
module xy_counter
    import layer_pkg::*;
#(
    parameter int WIDTH_N = 4,
    parameter bit WRAP    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_inc,
    input  logic                          i_clr,
    output logic [clog2_min1(WIDTH_N)-1:0] o_row,
    output logic [clog2_min1(WIDTH_N)-1:0] o_col,
    output logic                          o_last
);
    localparam int         W    = clog2_min1(WIDTH_N);
    localparam logic [W-1:0] LAST = W'(WIDTH_N - 1);

    logic [W-1:0] r_row;
    logic [W-1:0] r_col;

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == LAST) && (r_col == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc) begin
            if (o_last) begin
                if (WRAP) begin
                    r_row <= '0;
                    r_col <= '0;
                end
            end else if (r_col == LAST) begin
                r_col <= '0;
                r_row <= r_row + W'(1);
            end else begin
                r_col <= r_col + W'(1);
            end
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// Responder side of the layer control loop: arbitrates the phase strobes and
// steps channel indices, conv window and pool position for the datapath.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int IC    = 1,
    parameter int OC    = 1,
    parameter int IMG_W = 28,
    parameter int K     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    layer_sequencer_if.slave bus
);
    localparam int OW  = ow_of(IMG_W, K);
    localparam int PW  = pw_of(OW);
    localparam int ICW = clog2_min1(IC);
    localparam int OCW = clog2_min1(OC);
    localparam int WW  = clog2_min1(OW);
    localparam int PWW = clog2_min1(PW);

    localparam logic [ICW-1:0] IC_LAST = ICW'(IC - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(OC - 1);

    stb_e           w_stb;
    logic [2:0]     w_nstb;
    logic           w_win_inc;
    logic           w_win_clr;
    logic           w_win_last;
    logic           w_pool_inc;
    logic           w_pool_last;
    logic [WW-1:0]  w_win_row;
    logic [WW-1:0]  w_win_col;
    logic [PWW-1:0] w_pool_row;
    logic [PWW-1:0] w_pool_col;
    logic           w_ic_last;
    logic           w_oc_last;

    logic           r_conv_done;
    logic           r_proto_err;
    logic [ICW-1:0] r_ic;
    logic [OCW-1:0] r_oc;

    assign w_stb  = stb_pick(bus.c_load, bus.cout, bus.conv, bus.tree, bus.pool);
    assign w_nstb = 3'(bus.c_load) + 3'(bus.cout) + 3'(bus.conv)
                  + 3'(bus.tree) + 3'(bus.pool);

    assign w_ic_last  = (r_ic == IC_LAST);
    assign w_oc_last  = (r_oc == OC_LAST);
    assign w_win_clr  = (w_stb == STB_CLOAD);
    assign w_win_inc  = (w_stb == STB_CONV) && !r_conv_done;
    assign w_pool_inc = (w_stb == STB_POOL);

    xy_counter #(.WIDTH_N(OW), .WRAP(1'b0)) u_win_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_win_inc),
        .i_clr  (w_win_clr),
        .o_row  (w_win_row),
        .o_col  (w_win_col),
        .o_last (w_win_last)
    );

    xy_counter #(.WIDTH_N(PW), .WRAP(1'b1)) u_pool_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_pool_inc),
        .i_clr  (1'b0),
        .o_row  (w_pool_row),
        .o_col  (w_pool_col),
        .o_last (w_pool_last)
    );

    // conv_done marks that the edge consumed the final window; the window
    // counter itself holds on that corner until the next channel load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_done <= 1'b0;
            r_proto_err <= 1'b0;
            r_ic        <= '0;
            r_oc        <= '0;
        end else begin
            if (w_nstb > 3'd1)
                r_proto_err <= 1'b1;

            if (w_win_clr)
                r_conv_done <= 1'b0;
            else if (w_win_inc && w_win_last)
                r_conv_done <= 1'b1;

            if (w_stb == STB_COUT) begin
                if (w_ic_last) begin
                    r_ic <= '0;
                    r_oc <= w_oc_last ? '0 : r_oc + OCW'(1);
                end else begin
                    r_ic <= r_ic + ICW'(1);
                end
            end
        end
    end

    assign bus.conv_done  = r_conv_done;
    assign bus.proto_err  = r_proto_err;
    assign bus.ic_idx     = r_ic;
    assign bus.oc_idx     = r_oc;
    assign bus.win_row    = w_win_row;
    assign bus.win_col    = w_win_col;
    assign bus.pool_row   = w_pool_row;
    assign bus.pool_col   = w_pool_col;
    assign bus.win_valid  = w_win_inc;
    assign bus.acc_clr    = w_win_clr && (r_ic == '0);
    assign bus.tree_en    = (w_stb == STB_TREE);
    assign bus.cout_done  = (w_stb == STB_COUT) && w_ic_last && w_oc_last;
    assign bus.pool_valid = (w_stb == STB_POOL);
    assign bus.pool_done  = (w_stb == STB_POOL) && w_pool_last;
endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised and directed bench for layer_sequencer against a linear-index
// reference model (window, pool and channel positions as single counts).
module tb_layer_sequencer;
    localparam int IC    = 2;
    localparam int OC    = 2;
    localparam int IMG_W = 6;
    localparam int K     = 3;
    localparam int OW    = IMG_W - K + 1;
    localparam int PW    = OW / 2;
    localparam int NW    = OW * OW;
    localparam int NP    = PW * PW;
    localparam int NCH   = IC * OC;

    // strobe vector layout: {c_load, cout, conv, tree, pool}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_CLOAD = 5'b10000;
    localparam logic [4:0] S_COUT  = 5'b01000;
    localparam logic [4:0] S_CONV  = 5'b00100;
    localparam logic [4:0] S_TREE  = 5'b00010;
    localparam logic [4:0] S_POOL  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_sequencer_if #(.IC(IC), .OC(OC), .IMG_W(IMG_W), .K(K)) bus ();

    layer_sequencer #(.IC(IC), .OC(OC), .IMG_W(IMG_W), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: linear positions
    int m_w  = 0;   // windows consumed, saturates at NW
    int m_p  = 0;   // pool positions consumed mod NP
    int m_ch = 0;   // (ic,oc) pairs completed mod NCH
    bit m_perr = 0;

    int n_winv = 0, n_coutd = 0, n_accclr = 0, n_pdone = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] s);
        int  win;
        int  wl;
        bit  cd;
        int  ic;
        int  oc;
        @(negedge clk);
        {bus.c_load, bus.cout, bus.conv, bus.tree, bus.pool} = s;
        #1;
        if (s[4])      win = 1;
        else if (s[3]) win = 2;
        else if (s[2]) win = 3;
        else if (s[1]) win = 4;
        else if (s[0]) win = 5;
        else           win = 0;
        cd = (m_w == NW);
        wl = cd ? NW - 1 : m_w;
        ic = m_ch % IC;
        oc = m_ch / IC;

        chk("conv_done",  bus.conv_done,  cd);
        chk("ic_idx",     bus.ic_idx,     ic);
        chk("oc_idx",     bus.oc_idx,     oc);
        chk("win_row",    bus.win_row,    wl / OW);
        chk("win_col",    bus.win_col,    wl % OW);
        chk("pool_row",   bus.pool_row,   m_p / PW);
        chk("pool_col",   bus.pool_col,   m_p % PW);
        chk("proto_err",  bus.proto_err,  m_perr);
        chk("win_valid",  bus.win_valid,  (win == 3) && !cd);
        chk("acc_clr",    bus.acc_clr,    (win == 1) && (ic == 0));
        chk("tree_en",    bus.tree_en,    win == 4);
        chk("cout_done",  bus.cout_done,  (win == 2) && (m_ch == NCH - 1));
        chk("pool_valid", bus.pool_valid, win == 5);
        chk("pool_done",  bus.pool_done,  (win == 5) && (m_p == NP - 1));

        if (bus.win_valid) n_winv++;
        if (bus.cout_done) n_coutd++;
        if (bus.acc_clr)   n_accclr++;
        if (bus.pool_done) n_pdone++;

        if ($countones(s) > 1) m_perr = 1;
        case (win)
            1: m_w = 0;
            2: m_ch = (m_ch + 1) % NCH;
            3: if (!cd) m_w++;
            5: m_p = (m_p + 1) % NP;
            default: ;
        endcase
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        {bus.c_load, bus.cout, bus.conv, bus.tree, bus.pool} = S_NONE;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_conv_done",  bus.conv_done,  0);
        chk("rst_ic",         bus.ic_idx,     0);
        chk("rst_oc",         bus.oc_idx,     0);
        chk("rst_win_row",    bus.win_row,    0);
        chk("rst_win_col",    bus.win_col,    0);
        chk("rst_pool_row",   bus.pool_row,   0);
        chk("rst_pool_col",   bus.pool_col,   0);
        chk("rst_proto_err",  bus.proto_err,  0);
        chk("rst_win_valid",  bus.win_valid,  0);
        chk("rst_acc_clr",    bus.acc_clr,    0);
        chk("rst_tree_en",    bus.tree_en,    0);
        m_w = 0; m_p = 0; m_ch = 0; m_perr = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        {bus.c_load, bus.cout, bus.conv, bus.tree, bus.pool} = S_NONE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_reset();
        step(S_NONE);
        step(S_NONE);

        // full window sweep with conv held one cycle past the end
        n_winv = 0;
        step(S_CLOAD);
        repeat (NW + 1) step(S_CONV);
        chk("win_cnt_sweep", n_winv, NW);
        step(S_CONV);
        step(S_NONE);

        // conv interleaved with tree
        n_winv = 0;
        step(S_CLOAD);
        repeat (NW) begin
            step(S_CONV);
            step(S_TREE);
        end
        chk("win_cnt_tree", n_winv, NW);

        // four channel rounds
        do_reset();
        n_coutd = 0; n_accclr = 0;
        repeat (NCH) begin
            step(S_CLOAD);
            repeat (NW) step(S_CONV);
            step(S_TREE);
            step(S_COUT);
        end
        chk("cout_done_cnt", n_coutd, 1);
        chk("acc_clr_cnt",   n_accclr, 2);
        #1;
        chk("ic_wrapped", bus.ic_idx, 0);
        chk("oc_wrapped", bus.oc_idx, 0);

        // pool sweep
        n_pdone = 0;
        repeat (NP) step(S_POOL);
        chk("pool_done_cnt", n_pdone, 1);
        #1;
        chk("pool_row_wrap", bus.pool_row, 0);
        chk("pool_col_wrap", bus.pool_col, 0);

        // overlapping strobes
        step(S_CLOAD);
        step(S_CONV | S_COUT);
        repeat (3) step(S_CONV);
        #1;
        chk("proto_err_sticky", bus.proto_err, 1);
        do_reset();
        step(S_NONE);

        // reset mid-conv at window (2,1), then restart
        step(S_CLOAD);
        repeat (2 * OW + 1) step(S_CONV);
        #1;
        chk("midconv_row", bus.win_row, 2);
        chk("midconv_col", bus.win_col, 1);
        do_reset();
        step(S_CLOAD);
        repeat (3) step(S_CONV);

        // randomised traffic, mostly one-hot with occasional overlaps
        repeat (600) begin
            logic [4:0] s;
            if ($urandom_range(0, 7) == 0)
                s = 5'($urandom);
            else begin
                case ($urandom_range(0, 9))
                    0:       s = S_CLOAD;
                    1:       s = S_COUT;
                    2, 3, 4: s = S_CONV;
                    5:       s = S_TREE;
                    6, 7:    s = S_POOL;
                    default: s = S_NONE;
                endcase
            end
            step(s);
        end
        do_reset();
        step(S_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Responder side of the layer control handshake.
- Consumes the one-hot phase strobes (c_load, conv, tree, cout, pool) and generates the channel indices, convolution window coordinates and pooling coordinates for the datapath.
- Returns the conv_done, cout_done and pool_done status that closes the layer control loop.
- Sits between the layer controller FSM and the line buffer, MAC and pool datapath of one CNN layer.

Parameters:
- IC, 1, number of input channels per output channel (must be >= 1).
- OC, 1, number of output channels.
- IMG_W, 28, square input feature-map width.
- K, 3, square kernel width; convolution stride 1, no padding.
- Derived localparams: OW = IMG_W-K+1, conv output width; PW = OW/2, pool output width for 2x2 stride-2 pooling (OW even required).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- c_load  in  1  channel-load strobe
- conv  in  1  convolution step strobe, one window per high cycle
- tree  in  1  adder-tree accumulate strobe
- cout  in  1  channel count-out strobe
- pool  in  1  pool step strobe, one pool position per high cycle
- conv_done  out  1  registered; all OW*OW windows of the current channel issued
- cout_done  out  1  combinational; high with cout when the final (ic,oc) pair completes
- pool_done  out  1  combinational; high with pool on the last pool position
- ic_idx  out  $clog2(IC) min 1  current input channel
- oc_idx  out  $clog2(OC) min 1  current output channel
- win_valid  out  1  window coordinate valid this cycle
- win_row, win_col  out  $clog2(OW) min 1 each  top-left corner of the current window
- acc_clr  out  1  clear output-channel accumulator
- tree_en  out  1  adder-tree accumulate enable
- pool_valid  out  1  pool coordinate valid this cycle
- pool_row, pool_col  out  $clog2(PW) min 1 each  pool output coordinate
- proto_err  out  1  sticky; more than one strobe seen high in the same cycle

Behaviour:
- Reset (asynchronous, any time including mid-layer):
  - All counters, conv_done, proto_err, acc_clr and tree_en go to 0.
  - win_valid, pool_valid, cout_done and pool_done are 0 while no strobe is present.
- Strobe priority when strobes overlap: c_load > cout > conv > tree > pool. Only the winning strobe acts. proto_err sets and stays set until reset.
- c_load:
  - Clears win_row, win_col and conv_done on the next edge.
  - acc_clr = 1 for that same cycle (combinational) only when ic_idx == 0.
- conv cycle:
  - win_valid = conv & !conv_done, combinational; win_row and win_col reflect the current counters.
  - On the edge: win_col increments. At OW-1 it wraps to 0 and win_row increments.
  - When the edge consumes (OW-1, OW-1), conv_done is set and the counters hold. conv_done is therefore visible one cycle after the last win_valid.
  - conv held while conv_done = 1: no counter change, win_valid = 0.
- tree cycle: tree_en = 1 combinationally; no counter change. conv_done is unaffected and remains readable during tree.
- cout cycle:
  - cout_done = cout & (ic_idx == IC-1) & (oc_idx == OC-1).
  - On the edge: if ic_idx == IC-1, ic_idx goes to 0 and oc_idx increments (wrapping to 0 after OC-1); otherwise ic_idx increments.
  - After the final cout, both indices are back at 0.
- pool cycle:
  - pool_valid = 1 combinationally; pool_row and pool_col are the current counters.
  - pool_done = pool & (pool_row == PW-1) & (pool_col == PW-1).
  - On the edge: column-major-inner increment, same wrap rule as conv. The last position wraps both counters to 0.
- No strobe: all counters hold and all combinational outputs are 0.
- Widths: counters use the minimum width as specified; comparisons are against sized localparams. No arithmetic overflow is possible inside the valid ranges.

Decomposition:
- Shared package layer_pkg holds:
  - function clog2_min1;
  - strobe priority encoding constants (STB_NONE, STB_CLOAD, STB_COUT, STB_CONV, STB_TREE, STB_POOL);
  - OW and PW derivation functions.
- One natural sub-module: xy_counter. It is a parameterised (row,col) counter with WIDTH_N, inc, clr, last and wrap/hold mode. It is instantiated twice, once for conv windows (hold mode) and once for pool positions (wrap mode).

Test Plan (IMG_W=6, K=3 -> OW=4, PW=2; IC=2, OC=2 unless noted):
- Reset, then c_load for 1 cycle, then conv for 17 cycles -> win_valid for exactly 16 cycles with (0,0)..(3,3) in row-major order; conv_done rises on cycle 17 and win_valid = 0 while conv is held.
- Sequence c_load, then conv and tree alternating -> tree_en mirrors tree; window counter advances only on conv cycles; conv_done is seen during the tree cycle after the 16th window.
- Four c_load/conv/cout rounds -> (ic,oc) visits (0,0), (1,0), (0,1), (1,1); cout_done is high only on the 4th cout; acc_clr pulses on the 1st and 3rd c_load; indices return to (0,0).
- pool held for 4 cycles -> (0,0), (0,1), (1,0), (1,1); pool_done only in cycle 4; counters back at (0,0).
- conv and cout high together -> cout acts, window does not advance, proto_err sets and survives later clean cycles until rst_n goes low.
- rst_n asserted mid-conv at window (2,1) -> all outputs 0 immediately; after release, c_load plus conv restarts at (0,0).
